imem_ctrl: RTL and testbench
============================

// Module: imem_ctrl
// PURPOSE
// Access controller in front of the single-port instruction memory (sync write, 1-cycle sync read).
// After reset it runs a boot phase: a streamed program image is written to consecutive word addresses.
// It then shares the memory between the core fetch unit and a debug port, using round-robin arbitration.
// It routes each read response back to the requester that issued it.
// PARAMETERS
// N          5    word-address width; memory holds 2**N words
// PRIO_FETCH 1    1: fetch wins the first contention after boot; 0: debug wins it
// PORTS
// clk          in   1   clock, all logic on rising edge
// rst          in   1   asynchronous, active-high reset
// boot_start   in   1   1-cycle pulse, starts a boot load of boot_len words (accepted in RUN only)
// boot_len     in   N+1 number of words to load (1..2**N); sampled with boot_start
// boot_valid   in   1   boot stream word valid
// boot_data    in   32  boot stream word
// boot_ready   out  1   boot word accepted when boot_valid & boot_ready
// boot_busy    out  1   high in LOAD state
// boot_done    out  1   1-cycle pulse, final word written
// fetch_req    in   1   fetch read request
// fetch_addr   in   N   fetch word address
// fetch_gnt    out  1   fetch request granted this cycle
// fetch_rvalid out  1   fetch read data valid (one cycle after grant)
// fetch_rdata  out  32  fetch read data
// dbg_req      in   1   debug access request
// dbg_we       in   1   debug write (1) or read (0)
// dbg_addr     in   N   debug word address
// dbg_wdata    in   32  debug write data
// dbg_gnt      out  1   debug request granted this cycle
// dbg_rvalid   out  1   debug read data valid (one cycle after a granted read)
// dbg_rdata    out  32  debug read data
// mem_we       out  1   to imem we
// mem_addr     out  N   to imem addr
// mem_wdata    out  32  to imem data_in
// mem_rdata    in   32  from imem data_out
// BEHAVIOUR
// - FSM states: LOAD, RUN. Reset enters LOAD, with boot_len taken as 2**N and the counter at 0.
// - Reset values: boot_ready=0, boot_busy=1, boot_done=0, all gnt/rvalid=0, mem_we=0.
// - In LOAD:
//   - boot_ready=1 and both gnt=0; fetch_req and dbg_req are ignored (the requester holds its request).
//   - Each accepted word gives mem_we=1, mem_addr=cnt[N-1:0], mem_wdata=boot_data in that same cycle; cnt increments.
//   - The word with cnt==len-1 raises boot_done the next cycle, and the FSM goes to RUN. boot_valid=0 leaves cnt unchanged.
// - In RUN:
//   - boot_ready=0 and boot_busy=0.
//   - boot_start forces LOAD the next cycle, with cnt=0 and len=boot_len. boot_len=0 is treated as 2**N.
//   - boot_start has priority over any request pending in that same cycle; that request is not granted.
// - Arbitration (RUN only), combinational grant:
//   - Only one requester: it is granted.
//   - Both: the one not granted last is granted. The last-winner flag updates only on contention.
//   - The flag resets toward !PRIO_FETCH as the last winner, so that PRIO_FETCH wins first.
// - Muxing: mem_addr/mem_we/mem_wdata are driven from the granted requester. With no grant: mem_we=0, mem_addr=0.
// - Reads:
//   - A grant on a read at cycle t gives {fetch|dbg}_rvalid=1 at t+1, with rdata = mem_rdata.
//   - A 1-bit owner register records who gets the t+1 response.
//   - rdata outputs pass mem_rdata through and are don't-care while rvalid=0.
// - Writes: a dbg write is granted and completes in the same cycle, with no rvalid.
// - Back-to-back grants are allowed every cycle, giving full throughput for a single requester.
// - Read-after-write to the same address on consecutive cycles returns the new data (memory timing).
// - Async reset mid-LOAD or mid-read: all state clears immediately and no rvalid follows. Memory contents are untouched.
// TESTING
// - Reset, stream 32 words 0xA0+i with gaps in boot_valid -> mem writes at addr 0..31, boot_done pulses once, state RUN.
// - RUN, fetch_req only, addr 3,4,5 in consecutive cycles -> fetch_gnt each cycle, rvalid at t+1..t+3 with words 0xA3..0xA5.
// - fetch_req and dbg_req both held high for 4 cycles (PRIO_FETCH=1) -> grants F,D,F,D, and each rvalid reaches the correct requester.
// - dbg write 0xDEADBEEF to addr 7, then fetch read addr 7 next cycle -> fetch_rdata=0xDEADBEEF.
// - boot_start with boot_len=2 while fetch_req high -> no fetch_gnt, 2 words written to addr 0..1, boot_done, then fetch granted.
// - Assert rst during LOAD after 5 words -> boot_ready drops immediately, restart loads from addr 0; rst in the grant cycle -> no rvalid.

Source files
------------

// File: rtl/imem_ctrl.sv
// Instruction memory access controller: streams a boot image into memory after reset,
// then arbitrates fetch and debug accesses round-robin and routes read responses back.
module imem_ctrl #(
    parameter int unsigned N          = 5,
    parameter bit          PRIO_FETCH = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          boot_start_i,
    input  logic [N:0]    boot_len_i,
    input  logic          boot_valid_i,
    input  logic [31:0]   boot_data_i,
    output logic          boot_ready_o,
    output logic          boot_busy_o,
    output logic          boot_done_o,
    input  logic          fetch_req_i,
    input  logic [N-1:0]  fetch_addr_i,
    output logic          fetch_gnt_o,
    output logic          fetch_rvalid_o,
    output logic [31:0]   fetch_rdata_o,
    input  logic          dbg_req_i,
    input  logic          dbg_we_i,
    input  logic [N-1:0]  dbg_addr_i,
    input  logic [31:0]   dbg_wdata_i,
    output logic          dbg_gnt_o,
    output logic          dbg_rvalid_o,
    output logic [31:0]   dbg_rdata_o,
    output logic          mem_we_o,
    output logic [N-1:0]  mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    localparam int unsigned CW = N + 1;
    localparam logic [CW-1:0] FULL_LEN = CW'(1) << N;

    typedef enum logic {S_LOAD, S_RUN} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len_q, len_d;
    logic          boot_ready_q;
    logic          boot_busy_q;
    logic          boot_done_q;
    logic          last_fetch_q;
    logic          rd_pend_q;
    logic          rd_owner_fetch_q;

    logic arb_en;
    logic contention;
    logic fetch_gnt;
    logic dbg_gnt;
    logic boot_acc;
    logic boot_last;

    // A boot request in RUN pre-empts arbitration for that cycle
    assign arb_en     = (state_q == S_RUN) && !boot_start_i;
    assign contention = fetch_req_i && dbg_req_i;
    assign fetch_gnt  = arb_en && fetch_req_i && (!dbg_req_i || !last_fetch_q);
    assign dbg_gnt    = arb_en && dbg_req_i && (!fetch_req_i || last_fetch_q);

    assign boot_acc  = (state_q == S_LOAD) && boot_valid_i && boot_ready_q;
    assign boot_last = boot_acc && (cnt_q == len_q - CW'(1));
    assign cnt_d     = cnt_q + CW'(1);
    assign len_d     = (boot_len_i == '0) ? FULL_LEN : boot_len_i;

    // Memory port mux: boot writer in LOAD, granted requester in RUN
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = dbg_wdata_i;
        if (boot_acc) begin
            mem_we_o    = 1'b1;
            mem_addr_o  = cnt_q[N-1:0];
            mem_wdata_o = boot_data_i;
        end else if (fetch_gnt) begin
            mem_addr_o  = fetch_addr_i;
        end else if (dbg_gnt) begin
            mem_we_o    = dbg_we_i;
            mem_addr_o  = dbg_addr_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_LOAD;
            cnt_q            <= '0;
            len_q            <= FULL_LEN;
            boot_ready_q     <= 1'b0;
            boot_busy_q      <= 1'b1;
            boot_done_q      <= 1'b0;
            last_fetch_q     <= !PRIO_FETCH;
            rd_pend_q        <= 1'b0;
            rd_owner_fetch_q <= 1'b0;
        end else begin
            boot_done_q      <= 1'b0;
            rd_pend_q        <= fetch_gnt || (dbg_gnt && !dbg_we_i);
            rd_owner_fetch_q <= fetch_gnt;
            if (arb_en && contention) begin
                last_fetch_q <= fetch_gnt;
            end
            case (state_q)
                S_LOAD: begin
                    boot_ready_q <= 1'b1;
                    boot_busy_q  <= 1'b1;
                    if (boot_acc) begin
                        cnt_q <= cnt_d;
                    end
                    if (boot_last) begin
                        state_q      <= S_RUN;
                        boot_done_q  <= 1'b1;
                        boot_ready_q <= 1'b0;
                        boot_busy_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    boot_ready_q <= 1'b0;
                    boot_busy_q  <= 1'b0;
                    if (boot_start_i) begin
                        state_q      <= S_LOAD;
                        cnt_q        <= '0;
                        len_q        <= len_d;
                        boot_ready_q <= 1'b1;
                        boot_busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign boot_ready_o   = boot_ready_q;
    assign boot_busy_o    = boot_busy_q;
    assign boot_done_o    = boot_done_q;
    assign fetch_gnt_o    = fetch_gnt;
    assign dbg_gnt_o      = dbg_gnt;
    assign fetch_rvalid_o = rd_pend_q && rd_owner_fetch_q;
    assign dbg_rvalid_o   = rd_pend_q && !rd_owner_fetch_q;
    assign fetch_rdata_o  = mem_rdata_i;
    assign dbg_rdata_o    = mem_rdata_i;

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: attached memory, transaction-level reference model,
// directed scenarios followed by randomized traffic.
module tb_imem_ctrl;

    localparam int unsigned N     = 5;
    localparam int unsigned DEPTH = 1 << N;

    logic          clk = 1'b0;
    logic          rst;
    logic          boot_start;
    logic [N:0]    boot_len;
    logic          boot_valid;
    logic [31:0]   boot_data;
    logic          boot_ready, boot_busy, boot_done;
    logic          fetch_req;
    logic [N-1:0]  fetch_addr;
    logic          fetch_gnt, fetch_rvalid;
    logic [31:0]   fetch_rdata;
    logic          dbg_req, dbg_we;
    logic [N-1:0]  dbg_addr;
    logic [31:0]   dbg_wdata;
    logic          dbg_gnt, dbg_rvalid;
    logic [31:0]   dbg_rdata;
    logic          mem_we;
    logic [N-1:0]  mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    imem_ctrl #(.N(N), .PRIO_FETCH(1'b1)) dut (
        .clk(clk), .rst(rst),
        .boot_start_i(boot_start), .boot_len_i(boot_len),
        .boot_valid_i(boot_valid), .boot_data_i(boot_data),
        .boot_ready_o(boot_ready), .boot_busy_o(boot_busy), .boot_done_o(boot_done),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
        .fetch_gnt_o(fetch_gnt), .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory: synchronous write, one-cycle synchronous read
    logic [31:0] imem [DEPTH];
    always @(posedge clk) begin
        if (mem_we) imem[mem_addr] <= mem_wdata;
        mem_rdata <= imem[mem_addr];
    end

    // Reference model state
    bit          m_loading;
    int          m_cnt, m_len;
    bit          m_fetch_turn;
    bit          m_pend, m_pend_fetch;
    logic [31:0] m_pend_data;
    bit          m_done;
    logic [31:0] ref_mem [DEPTH];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_loading    = 1'b1;
        m_cnt        = 0;
        m_len        = DEPTH;
        m_fetch_turn = 1'b1;
        m_pend       = 1'b0;
        m_done       = 1'b0;
    endtask

    // Asynchronous reset applied mid-cycle; memory contents are left alone
    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_boot_ready", boot_ready, 0);
        chk("rst_boot_busy", boot_busy, 1);
        chk("rst_boot_done", boot_done, 0);
        chk("rst_fetch_gnt", fetch_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_fetch_rvalid", fetch_rvalid, 0);
        chk("rst_dbg_rvalid", dbg_rvalid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_fetch_rvalid", fetch_rvalid, 0);
        chk("rst_hold_dbg_rvalid", dbg_rvalid, 0);
        rst = 1'b0;
        #1;
        chk("rst_rel_boot_ready", boot_ready, 0);
        chk("rst_rel_boot_busy", boot_busy, 1);
        model_reset();
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model
    task automatic cyc(input bit fr, input int fa, input bit dr, input bit dw, input int da,
                       input logic [31:0] dd, input bit bs, input int bl,
                       input bit bv, input logic [31:0] bdat);
        bit efg, edg, acc, ewe;
        int eaddr;
        @(negedge clk);
        fetch_req  = fr;
        fetch_addr = N'(fa);
        dbg_req    = dr;
        dbg_we     = dw;
        dbg_addr   = N'(da);
        dbg_wdata  = dd;
        boot_start = bs;
        boot_len   = (N+1)'(bl);
        boot_valid = bv;
        boot_data  = bdat;
        #1;
        efg = 1'b0;
        edg = 1'b0;
        acc = 1'b0;
        if (m_loading) begin
            acc = bv;
        end else if (!bs) begin
            if (fr && dr) begin
                efg = m_fetch_turn;
                edg = !m_fetch_turn;
            end else begin
                efg = fr;
                edg = dr;
            end
        end
        ewe   = acc || (edg && dw);
        eaddr = acc ? m_cnt : (efg ? fa : (edg ? da : 0));
        chk("boot_ready", boot_ready, m_loading);
        chk("boot_busy", boot_busy, m_loading);
        chk("boot_done", boot_done, m_done);
        chk("fetch_gnt", fetch_gnt, efg);
        chk("dbg_gnt", dbg_gnt, edg);
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", 32'(mem_addr), 32'(eaddr));
        if (ewe) chk("mem_wdata", mem_wdata, acc ? bdat : dd);
        chk("fetch_rvalid", fetch_rvalid, m_pend && m_pend_fetch);
        chk("dbg_rvalid", dbg_rvalid, m_pend && !m_pend_fetch);
        if (m_pend && m_pend_fetch) chk("fetch_rdata", fetch_rdata, m_pend_data);
        if (m_pend && !m_pend_fetch) chk("dbg_rdata", dbg_rdata, m_pend_data);

        m_done       = 1'b0;
        m_pend       = efg || (edg && !dw);
        m_pend_fetch = efg;
        m_pend_data  = efg ? ref_mem[fa] : ref_mem[da];
        if (edg && dw) ref_mem[da] = dd;
        if (fr && dr && (efg || edg)) m_fetch_turn = edg;
        if (m_loading) begin
            if (acc) begin
                ref_mem[m_cnt] = bdat;
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                end
            end
        end else if (bs) begin
            m_loading = 1'b1;
            m_cnt     = 0;
            m_len     = (bl == 0) ? DEPTH : bl;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Feed the boot stream with random gaps and ignored requests until the load completes
    task automatic boot_stream(input bit use_a0);
        for (int i = 0; i < 400 && m_loading; i++) begin
            cyc($urandom_range(0, 1), $urandom_range(0, DEPTH-1), $urandom_range(0, 1), 1'b0,
                $urandom_range(0, DEPTH-1), $urandom, 0, 0, ($urandom_range(0, 3) != 0),
                use_a0 ? 32'(32'hA0 + m_cnt) : $urandom);
        end
        idle(1);
    endtask

    initial begin
        boot_start = 0; boot_len = '0; boot_valid = 0; boot_data = '0;
        fetch_req = 0; fetch_addr = '0; dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;

        // Boot image 0xA0+i into all words
        apply_reset();
        boot_stream(1'b1);
        chk("boot_img_word31", ref_mem[31], 32'hBF);

        // Sequential fetches of words 3,4,5
        cyc(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Contention for four cycles: fetch first, then alternating
        for (int i = 0; i < 4; i++)
            cyc(1, $urandom_range(0, DEPTH-1), 1, 0, $urandom_range(0, DEPTH-1), 0, 0, 0, 0, 0);
        idle(1);

        // Debug write then fetch read of the same word on the next cycle
        cyc(0, 0, 1, 1, 7, 32'hDEADBEEF, 0, 0, 0, 0);
        cyc(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Short boot while fetch keeps requesting
        cyc(1, 9, 0, 0, 0, 0, 1, 2, 0, 0);
        cyc(1, 9, 0, 0, 0, 0, 0, 0, 1, 32'h1111_0000);
        cyc(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 9, 0, 0, 0, 0, 0, 0, 1, 32'h1111_0001);
        cyc(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Randomized traffic with occasional short reloads
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 1), $urandom_range(0, DEPTH-1),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, DEPTH-1), $urandom,
                ($urandom_range(0, 39) == 0), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom);
        end
        while (m_loading) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, $urandom);
        idle(1);

        // Reset after five words of a full reload, then reload from word 0
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, $urandom);
        apply_reset();
        boot_stream(1'b0);

        // Reset asserted in the cycle a fetch is granted
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = N'(12);
        #1;
        chk("grant_before_rst", fetch_gnt, 1);
        apply_reset();
        boot_stream(1'b0);

        for (int i = 0; i < 40; i++)
            cyc($urandom_range(0, 1), $urandom_range(0, DEPTH-1),
                $urandom_range(0, 1), 0, $urandom_range(0, DEPTH-1), 0, 0, 0, 0, 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
